// File: rtl/layer_argmax.sv
// layer_argmax: scans sl signed n-bit elements one per clock and reports the index/value of the largest.
// Defining ARGMAX_MARGIN_EN adds runner-up tracking so low_conf flags a winner margin below MARGIN.
module layer_argmax #(
   parameter int sl = 2,
   parameter int n = 16,
   parameter int MARGIN = 0,
   parameter int IW = (sl > 1) ? $clog2(sl) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [n*sl-1:0]     ly,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [IW-1:0]       class_idx,
   output logic signed [n-1:0] max_val,
   output logic                low_conf,
   output logic                out_valid,
   input  logic                out_ready
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
   state_t state, nstate;
   logic signed [n-1:0] vec [sl];
   logic [IW-1:0] ptr;
   logic signed [n-1:0] elem;
   logic gt, last, accept;
   assign elem = vec[ptr];
   assign gt = elem > max_val;
   assign last = ptr == IW'(sl - 1);
   assign accept = state == IDLE && in_valid;
   assign in_ready = state == IDLE && !rst;
   assign out_valid = state == DONE;
   always_comb begin
      nstate = state;
      if (state == IDLE) nstate = in_valid ? ((sl > 1) ? SCAN : DONE) : IDLE;
      else if (state == SCAN) nstate = last ? DONE : SCAN;
      else nstate = out_ready ? IDLE : DONE;
   end
   // The input vector is captured once; later changes on ly are ignored.
   always_ff @(posedge clk)
      if (accept)
         for (int k = 0; k < sl; k++) vec[k] <= ly[n*k +: n];
   // max_val/class_idx double as the running max/index during the scan.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         class_idx <= '0;
         max_val <= '0;
         ptr <= '0;
      end else begin
         state <= nstate;
         if (accept) begin
            max_val <= ly[n-1:0];
            class_idx <= '0;
            ptr <= IW'((sl > 1) ? 1 : 0);
         end else if (state == SCAN) begin
            if (gt) begin
               max_val <= elem;
               class_idx <= ptr;
            end
            ptr <= last ? ptr : ptr + 1'b1;
         end
      end
`ifdef ARGMAX_MARGIN_EN
   logic signed [n-1:0] sec, nmax, nsec;
   logic signed [n:0] margin;
   assign nmax = gt ? elem : max_val;
   assign nsec = gt ? max_val : (elem > sec ? elem : sec);
   assign margin = {nmax[n-1], nmax} - {nsec[n-1], nsec};
   // Runner-up starts at the most negative value so any later element can claim it.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sec <= '0;
         low_conf <= 1'b0;
      end else if (accept) begin
         sec <= {1'b1, {(n-1){1'b0}}};
         low_conf <= 1'b0;
      end else if (state == SCAN) begin
         sec <= nsec;
         if (last) low_conf <= 32'(margin) < MARGIN;
      end
`else
   logic unused_margin;
   assign unused_margin = |MARGIN;
   assign low_conf = 1'b0;
`endif
endmodule
